ysyx_20020207_idu_queue: RTL and testbench

//  Decode stage with a DEPTH-entry instruction queue between IFU and EXU. Buffers {pc,inst} beats

---
 rtl/ysyx_20020207_idu_queue.sv | 135 +++++++++++++
 tb/tb_ysyx_20020207_idu_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_20020207_idu_queue.sv
// Decode stage with a DEPTH-entry {pc,inst} queue between IFU and EXU.
// Ports: clock/reset (sync, active-high), jump (flush), inst_in/pc_in/in_valid/in_ready (IFU side),
//   out_valid/out_ready + decoded head fields pc_out/op/func/rd/rs1/rs2/imm, count (occupancy).
// Optional IDU_ILLEGAL_DETECT_EN adds port illegal (head opcode not a known RV32 opcode).
module ysyx_20020207_idu_queue #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       jump,
    input  logic [31:0]                inst_in,
    input  logic [PC_W-1:0]            pc_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            pc_out,
    output logic [6:0]                 op,
    output logic [2:0]                 func,
    output logic [4:0]                 rd,
    output logic [4:0]                 rs1,
    output logic [4:0]                 rs2,
    output logic [31:0]                imm,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef IDU_ILLEGAL_DETECT_EN
    ,
    output logic                       illegal
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    assign in_ready  = (cnt != CW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign count     = cnt;

    // A flush wins over both handshakes: the offered beat is dropped
    // and the head is not consumed.
    assign push = in_valid & in_ready & ~jump;
    assign pop  = out_valid & out_ready & ~jump;

    // DEPTH is a power of two, so pointers wrap naturally at AW bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (jump) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: pc_in, inst: inst_in};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push & ~pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop & ~push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    logic [31:0] ins;
    assign ins    = mem[rd_ptr].inst;
    assign pc_out = mem[rd_ptr].pc;
    assign op     = ins[6:0];
    assign rd     = ins[11:7];
    assign func   = ins[14:12];
    assign rs1    = ins[19:15];
    assign rs2    = ins[24:20];

    logic is_i, is_s, is_b, is_j, is_u, is_r;
    assign is_i = (op == OP_LOAD) | (op == OP_IMM)
                | (op == OP_JALR) | (op == OP_SYSTEM);
    assign is_s = (op == OP_STORE);
    assign is_b = (op == OP_BRANCH);
    assign is_j = (op == OP_JAL);
    assign is_u = (op == OP_LUI) | (op == OP_AUIPC);
    assign is_r = (op == OP_REG);

    always_comb begin
        imm = '0;
        unique case (1'b1)
            is_i:    imm = {{20{ins[31]}}, ins[31:20]};
            is_s:    imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            is_b:    imm = {{19{ins[31]}}, ins[31], ins[7],
                            ins[30:25], ins[11:8], 1'b0};
            is_j:    imm = {{11{ins[31]}}, ins[31], ins[19:12],
                            ins[20], ins[30:21], 1'b0};
            is_u:    imm = {ins[31:12], 12'b0};
            is_r:    imm = {25'b0, ins[31:25]};
            default: imm = '0;
        endcase
    end

`ifdef IDU_ILLEGAL_DETECT_EN
    logic known;
    assign known   = is_i | is_s | is_b | is_j | is_u | is_r;
    assign illegal = out_valid & ~known;
`endif

endmodule

// File: tb/tb_ysyx_20020207_idu_queue.sv
// Scoreboard bench for ysyx_20020207_idu_queue (DEPTH=2).
// Directed vectors with hand-decoded expected head fields.
module tb_ysyx_20020207_idu_queue;

    localparam int DEPTH = 2;
    localparam int PC_W  = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 0;
    logic          reset = 1;
    logic          jump = 0;
    logic [31:0]   inst_in = '0;
    logic [31:0]   pc_in = '0;
    logic          in_valid = 0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 0;
    logic [31:0]   pc_out;
    logic [6:0]    op;
    logic [2:0]    func;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [31:0]   imm;
    logic [CW-1:0] count;
`ifdef IDU_ILLEGAL_DETECT_EN
    logic          illegal;
`endif

    ysyx_20020207_idu_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clock(clock), .reset(reset), .jump(jump),
        .inst_in(inst_in), .pc_in(pc_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .op(op), .func(func),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .count(count)
`ifdef IDU_ILLEGAL_DETECT_EN
        , .illegal(illegal)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  func;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   mc = 0;

    function automatic exp_t mk(input logic [31:0] pc, input logic [6:0] o,
                                input logic [4:0] d, input logic [2:0] f,
                                input logic [4:0] s1, input logic [4:0] s2,
                                input logic [31:0] im, input logic il);
        exp_t e;
        e.pc = pc; e.op = o; e.rd = d; e.func = f;
        e.rs1 = s1; e.rs2 = s2; e.imm = im; e.ill = il;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: compare head against scoreboard whenever EXU takes it.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready && !jump) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got pc %h want none", pc_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pc_out", pc_out, e.pc);
                chk("op", 32'(op), 32'(e.op));
                chk("rd", 32'(rd), 32'(e.rd));
                chk("func", 32'(func), 32'(e.func));
                chk("rs1", 32'(rs1), 32'(e.rs1));
                chk("rs2", 32'(rs2), 32'(e.rs2));
                chk("imm", imm, e.imm);
`ifdef IDU_ILLEGAL_DETECT_EN
                chk("illegal", 32'(illegal), 32'(e.ill));
`endif
            end
        end
    end

    // One cycle of stimulus; state checked against the occupancy model.
    task automatic step(input logic v, input logic [31:0] pc,
                        input logic [31:0] ins, input exp_t e,
                        input logic rdy, input logic j);
        bit p, q;
        in_valid = v; pc_in = pc; inst_in = ins;
        out_ready = rdy; jump = j;
        @(negedge clock);
        chk("count", 32'(count), 32'(mc));
        chk("in_ready", 32'(in_ready), 32'(mc != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(mc != 0));
        @(posedge clock);
        if (j) begin
            sb.delete();
            mc = 0;
        end else begin
            p = v && (mc != DEPTH);
            q = rdy && (mc != 0);
            if (p) sb.push_back(e);
            mc = mc + int'(p) - int'(q);
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(0, '0, '0, '0, rdy, 0);
    endtask

    exp_t e_addi, e_beq, e_jal, e_lui, e_sw, e_cus, e_sub, e_lw, e_aui;

    initial begin
        e_addi = mk(32'h8000_0000, 7'h13, 5'd1,  3'd0, 5'd0, 5'd5,  32'h0000_0005, 0);
        e_beq  = mk(32'h8000_0004, 7'h63, 5'h1D, 3'd0, 5'd0, 5'd0,  32'hFFFF_FFFC, 0);
        e_jal  = mk(32'h8000_0008, 7'h6F, 5'd0,  3'd0, 5'd0, 5'd0,  32'h0000_0000, 0);
        e_lui  = mk(32'h8000_0010, 7'h37, 5'd5,  3'd5, 5'd8, 5'd3,  32'h1234_5000, 0);
        e_sw   = mk(32'h8000_0014, 7'h23, 5'h1C, 3'd2, 5'd2, 5'd1,  32'hFFFF_FFFC, 0);
        e_sub  = mk(32'h8000_001C, 7'h33, 5'd3,  3'd0, 5'd1, 5'd2,  32'h0000_0020, 0);
        e_lw   = mk(32'h8000_0020, 7'h03, 5'd1,  3'd2, 5'd2, 5'h1C, 32'hFFFF_FFFC, 0);
        e_aui  = mk(32'h8000_0030, 7'h17, 5'd2,  3'd1, 5'd0, 5'd0,  32'h0000_1000, 0);
        e_cus  = mk(32'h8000_0040, 7'h0B, 5'd0,  3'd0, 5'd0, 5'd0,  32'h0000_0000, 1);

        // Reset state.
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_op", 32'(op), 32'd0);
        @(posedge clock);
        #1;

        // 1: single addi, visible next cycle.
        step(1, 32'h8000_0000, 32'h0050_0093, e_addi, 0, 0);
        idle(1);
        idle(0);

        // 2: fill, refused beat while full, then drain in order.
        step(1, 32'h8000_0004, 32'hFE00_0EE3, e_beq, 0, 0);
        step(1, 32'h8000_0008, 32'h0000_006F, e_jal, 0, 0);
        step(1, 32'h8000_000C, 32'h1234_52B7, e_lui, 0, 0);
        idle(0);
        idle(1);
        idle(1);
        idle(0);

        // 3: full with push+pop offered -> pop only; then push+pop at 1.
        step(1, 32'h8000_0010, 32'h1234_52B7, e_lui, 0, 0);
        step(1, 32'h8000_0014, 32'hFE11_2E23, e_sw, 0, 0);
        step(1, 32'h8000_0018, 32'h0000_000B, e_cus, 1, 0);
        step(1, 32'h8000_001C, 32'h4020_81B3, e_sub, 1, 0);
        step(1, 32'h8000_0020, 32'hFFC1_2083, e_lw, 1, 0);
        idle(1);
        idle(0);

        // 4: flush at count=2 with a beat offered; beat must vanish.
        step(1, 32'h8000_0030, 32'h0000_1117, e_aui, 0, 0);
        step(1, 32'h8000_0000, 32'h0050_0093, e_addi, 0, 0);
        step(1, 32'h0000_DEAD, 32'h0010_0113, '0, 1, 1);
        idle(1);
        step(1, 32'h8000_0040, 32'h0000_000B, e_cus, 0, 0);
        idle(1);
        step(1, 32'h8000_0000, 32'h0050_0093, e_addi, 0, 0);
        idle(1);
        idle(0);

        // Reset mid-traffic zeroes entry data too.
        step(1, 32'h8000_0004, 32'hFE00_0EE3, e_beq, 0, 0);
        step(1, 32'h8000_0008, 32'h0000_006F, e_jal, 0, 0);
        reset = 1;
        in_valid = 1; out_ready = 1;
        @(posedge clock);
        #1 reset = 0;
        sb.delete();
        mc = 0;
        in_valid = 0; out_ready = 0;
        @(negedge clock);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_pc_out", pc_out, 32'd0);
        chk("mid_rst_imm", imm, 32'd0);
        @(posedge clock);
        #1;

        idle(1);
        idle(1);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d left want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
